// File: rtl/data_mem_ctrl_if.sv
// rtl/data_mem_ctrl_if.sv - request/response bus between the MEM stage and the data memory
interface data_mem_ctrl_if #(
   parameter int DEPTH_LOG2 = 8
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [DEPTH_LOG2+1:0] req_addr;
   logic [1:0]            req_size;
   logic                  req_unsigned;
   logic [31:0]           req_wdata;
   logic                  rsp_valid;
   logic [31:0]           rsp_rdata;
   logic                  rsp_err;
   logic [31:0]           io_out;
   logic                  init_busy;

   modport master (
      output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, io_out, init_busy
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, io_out, init_busy
   );
endinterface

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - byte-lane data memory with sign/zero-extending loads and IO word mirror
// Clears the whole array after each reset before accepting requests.
module data_mem_ctrl #(
   parameter int DEPTH_LOG2 = 8,
   parameter int IO_WORD    = 0
) (
   input  logic          clk,
   input  logic          rst,
   data_mem_ctrl_if.slave bus
);
   localparam int WORDS = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] IO_IDX = DEPTH_LOG2'(IO_WORD);

   typedef enum logic {ST_INIT, ST_IDLE} state_t;

   state_t                state;
   logic [DEPTH_LOG2-1:0] clr_cnt;
   logic [31:0]           mem [WORDS];

   logic                  accept;
   logic                  req_err;
   logic [DEPTH_LOG2-1:0] req_idx;
   logic [1:0]            req_lane;
   logic [3:0]            st_lanes;
   logic [31:0]           st_data;
   logic [31:0]           rd_word;
   logic [7:0]            rd_byte;
   logic [15:0]           rd_half;
   logic [31:0]           ld_data;
   logic                  mem_we;
   logic [DEPTH_LOG2-1:0] mem_idx;
   logic [3:0]            mem_lanes;
   logic [31:0]           mem_wdata;

   always_comb begin
      req_idx  = bus.req_addr[DEPTH_LOG2+1:2];
      req_lane = bus.req_addr[1:0];
      accept   = (state == ST_IDLE) && bus.req_valid;

      req_err = 1'b0;
      case (bus.req_size)
         2'd1:    req_err = req_lane[0];
         2'd2:    req_err = (req_lane != 2'd0);
         2'd3:    req_err = 1'b1;
         default: req_err = 1'b0;
      endcase

      // Store data is replicated across lanes so the lane mask alone picks the bytes.
      st_lanes = 4'b0000;
      st_data  = bus.req_wdata;
      case (bus.req_size)
         2'd0: begin
            st_lanes = 4'b0001 << req_lane;
            st_data  = {4{bus.req_wdata[7:0]}};
         end
         2'd1: begin
            st_lanes = req_lane[1] ? 4'b1100 : 4'b0011;
            st_data  = {2{bus.req_wdata[15:0]}};
         end
         2'd2:    st_lanes = 4'b1111;
         default: st_lanes = 4'b0000;
      endcase

      rd_word = mem[req_idx];
      rd_byte = rd_word[{req_lane, 3'b000} +: 8];
      rd_half = rd_word[{req_lane[1], 4'b0000} +: 16];
      case (bus.req_size)
         2'd0:    ld_data = bus.req_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
         2'd1:    ld_data = bus.req_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
         2'd2:    ld_data = rd_word;
         default: ld_data = 32'd0;
      endcase

      if (state == ST_INIT) begin
         mem_we    = 1'b1;
         mem_idx   = clr_cnt;
         mem_lanes = 4'b1111;
         mem_wdata = 32'd0;
      end else begin
         mem_we    = accept && bus.req_we && !req_err;
         mem_idx   = req_idx;
         mem_lanes = st_lanes;
         mem_wdata = st_data;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_lanes[i]) mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_INIT;
         clr_cnt       <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= 32'd0;
         bus.rsp_err   <= 1'b0;
         bus.io_out    <= 32'd0;
         bus.req_ready <= 1'b0;
         bus.init_busy <= 1'b1;
      end else begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= 32'd0;
         bus.rsp_err   <= 1'b0;
         case (state)
            ST_INIT: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == IO_IDX) bus.io_out <= 32'd0;
               if (&clr_cnt) begin
                  state         <= ST_IDLE;
                  bus.req_ready <= 1'b1;
                  bus.init_busy <= 1'b0;
               end
            end
            ST_IDLE: begin
               if (accept) begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= req_err;
                  if (!req_err && !bus.req_we) bus.rsp_rdata <= ld_data;
               end
               // Shadow of the IO word takes the same lane merge as the array.
               if (mem_we && (req_idx == IO_IDX)) begin
                  for (int i = 0; i < 4; i++) begin
                     if (st_lanes[i]) bus.io_out[8*i +: 8] <= st_data[8*i +: 8];
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - randomized and directed bench for data_mem_ctrl against a word-array model
module tb_data_mem_ctrl;
   localparam int DL2   = 4;
   localparam int NW    = 1 << DL2;
   localparam int IO_W  = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   data_mem_ctrl_if #(.DEPTH_LOG2(DL2)) bus ();

   data_mem_ctrl #(.DEPTH_LOG2(DL2), .IO_WORD(IO_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [31:0] mem_m [NW];
   int          busy_left;
   logic [31:0] last_rdata;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // Reference behaviour: returns the response data/err and updates mem_m.
   task automatic model_access(output logic [31:0] rd, output logic er);
      int idx, lane, sz;
      logic [31:0] w, mask, v;
      idx  = int'(bus.req_addr) / 4;
      lane = int'(bus.req_addr) % 4;
      sz   = int'(bus.req_size);
      rd   = 32'd0;
      er   = (sz == 3) || (sz == 1 && (lane % 2) != 0) || (sz == 2 && lane != 0);
      if (er) return;
      w = mem_m[idx];
      if (bus.req_we) begin
         if (sz == 2) mem_m[idx] = bus.req_wdata;
         else begin
            mask = (sz == 0) ? 32'hFF : 32'hFFFF;
            mem_m[idx] = (w & ~(mask << (8 * lane))) | ((bus.req_wdata & mask) << (8 * lane));
         end
      end else begin
         if (sz == 2) rd = w;
         else if (sz == 0) begin
            v = (w >> (8 * lane)) & 32'hFF;
            if (!bus.req_unsigned && v >= 32'h80) v = v | 32'hFFFFFF00;
            rd = v;
         end else begin
            v = (w >> (8 * lane)) & 32'hFFFF;
            if (!bus.req_unsigned && v >= 32'h8000) v = v | 32'hFFFF0000;
            rd = v;
         end
      end
   endtask

   task automatic tick();
      logic acc;
      logic [31:0] er_d;
      logic ee;
      @(posedge clk);
      acc  = bus.req_valid && (busy_left == 0);
      er_d = 32'd0;
      ee   = 1'b0;
      if (busy_left > 0) busy_left--;
      if (acc) model_access(er_d, ee);
      @(negedge clk);
      check("rsp_valid", 32'(bus.rsp_valid), 32'(acc));
      check("rsp_rdata", bus.rsp_rdata, er_d);
      check("rsp_err", 32'(bus.rsp_err), 32'(ee));
      check("req_ready", 32'(bus.req_ready), 32'(busy_left == 0));
      check("init_busy", 32'(bus.init_busy), 32'(busy_left != 0));
      check("io_out", bus.io_out, mem_m[IO_W]);
      last_rdata = bus.rsp_rdata;
   endtask

   task automatic drive(input logic v, input logic we, input int addr, input int sz,
                        input logic uns, input logic [31:0] wd);
      bus.req_valid    = v;
      bus.req_we       = we;
      bus.req_addr     = 6'(addr);
      bus.req_size     = 2'(sz);
      bus.req_unsigned = uns;
      bus.req_wdata    = wd;
   endtask

   task automatic issue(input logic we, input int addr, input int sz, input logic uns,
                        input logic [31:0] wd);
      drive(1'b1, we, addr, sz, uns, wd);
      tick();
   endtask

   task automatic idle(input int n);
      drive(1'b0, 1'b0, 0, 0, 1'b0, 32'd0);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Called at a negedge; asserts reset mid-cycle so the async clear is visible at once.
   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_io_out", bus.io_out, 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_init_busy", 32'(bus.init_busy), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NW; i++) mem_m[i] = 32'd0;
      busy_left = NW;
   endtask

   task automatic sweep_check();
      int busy_cycles;
      busy_cycles = 0;
      drive(1'b0, 1'b0, 0, 0, 1'b0, 32'd0);
      for (int i = 0; i < NW + 2; i++) begin
         tick();
         if (bus.init_busy) busy_cycles++;
      end
      check("busy_cycles", 32'(busy_cycles), 32'(NW - 1));
      for (int i = 0; i < NW; i++) begin
         issue(1'b0, i * 4, 2, 1'b0, 32'd0);
         check("zero_word", last_rdata, 32'd0);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      drive(1'b0, 1'b0, 0, 0, 1'b0, 32'd0);
      for (int i = 0; i < NW; i++) mem_m[i] = 32'd0;
      busy_left = NW;
      @(negedge clk);
      do_reset();
      // One tick after release already ran out of the 16-cycle window: count ticks with busy high.
      sweep_check();

      issue(1'b1, 8, 2, 1'b0, 32'h80FF7F01);
      issue(1'b0, 8, 0, 1'b0, 32'd0);  check("tp_lb8",   last_rdata, 32'h00000001);
      issue(1'b0, 8, 0, 1'b1, 32'd0);  check("tp_lbu8",  last_rdata, 32'h00000001);
      issue(1'b0, 10, 1, 1'b0, 32'd0); check("tp_lhA",   last_rdata, 32'hFFFF80FF);
      issue(1'b0, 10, 1, 1'b1, 32'd0); check("tp_lhuA",  last_rdata, 32'h000080FF);
      issue(1'b0, 11, 0, 1'b0, 32'd0); check("tp_lbB",   last_rdata, 32'hFFFFFF80);
      issue(1'b0, 11, 0, 1'b1, 32'd0); check("tp_lbuB",  last_rdata, 32'h00000080);

      issue(1'b1, 4, 2, 1'b0, 32'hAABBCCDD);
      issue(1'b1, 5, 0, 1'b0, 32'h00000011);
      issue(1'b1, 6, 1, 1'b0, 32'h00002233);
      issue(1'b0, 4, 2, 1'b0, 32'd0);  check("tp_merge", last_rdata, 32'h223311DD);

      issue(1'b1, 3, 1, 1'b0, 32'hFFFFFFFF); check("tp_err_lh3", 32'(bus.rsp_err), 32'd1);
      issue(1'b1, 6, 2, 1'b0, 32'hFFFFFFFF); check("tp_err_lw6", 32'(bus.rsp_err), 32'd1);
      issue(1'b1, 0, 3, 1'b0, 32'hFFFFFFFF); check("tp_err_sz3", 32'(bus.rsp_err), 32'd1);
      issue(1'b0, 0, 2, 1'b0, 32'd0);  check("tp_unch0", last_rdata, 32'h00000000);
      issue(1'b0, 4, 2, 1'b0, 32'd0);  check("tp_unch4", last_rdata, 32'h223311DD);
      idle(1);

      issue(1'b1, IO_W * 4, 2, 1'b0, 32'h12345678);
      check("tp_io_after_sw", bus.io_out, 32'h12345678);
      check("tp_b2b_v0", 32'(bus.rsp_valid), 32'd1);
      issue(1'b0, IO_W * 4, 2, 1'b0, 32'd0);
      check("tp_b2b_v1", 32'(bus.rsp_valid), 32'd1);
      check("tp_b2b_ld", last_rdata, 32'h12345678);

      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 63),
               $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom);
         tick();
      end

      issue(1'b1, IO_W * 4, 2, 1'b0, 32'hCAFEF00D);
      check("pre_rst_io", bus.io_out, 32'hCAFEF00D);
      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive($urandom_range(0, 1) == 1, 1'b1, $urandom_range(0, 63), 2, 1'b0, $urandom);
         tick();
      end
      do_reset();
      sweep_check();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
